timer_counter: RTL and testbench

Memory-mapped down-counting timer that is the device (responder) end of the CPU data-bus store/load path and the source end of the external-interrupt path into CP0. The CPU reads and writes its three registers through the system bridge; the timer counts down from a preset and raises `irq`, which feeds the CP0 hardware-interrupt input. This exercises the exception/interrupt logic end to end.

---
 rtl/timer_counter.sv | 112 +++++++++++
 tb/tb_timer_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a
// maskable interrupt request for the CP0 hardware-interrupt input.
module timer_counter #(
   parameter logic [31:0] RESET_PRESET = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

   state_e      state_q, state_d;
   logic        en_q, en_d;
   logic [1:0]  mode_q, mode_d;
   logic        im_q, im_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        flag_q, flag_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         en_q     <= 1'b0;
         mode_q   <= 2'd0;
         im_q     <= 1'b0;
         preset_q <= RESET_PRESET;
         count_q  <= 32'd0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         en_q     <= en_d;
         mode_q   <= mode_d;
         im_q     <= im_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      preset_d = preset_q;
      count_d  = count_q;
      flag_d   = flag_q;

      unique case (state_q)
         StIdle: begin
            if (en_q) state_d = StLoad;
         end
         StLoad: begin
            count_d = preset_q;
            state_d = StCnt;
         end
         StCnt: begin
            if (!en_q) begin
               state_d = StIdle;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d = 32'd0;
               flag_d  = 1'b1;
               state_d = StInt;
            end
         end
         StInt: begin
            state_d = StIdle;
            // Only MODE 1 is periodic; 2 and 3 fall back to one-shot.
            if (mode_q == 2'd1) flag_d = 1'b0;
            else                en_d   = 1'b0;
         end
         default: state_d = StIdle;
      endcase

      // Software writes are applied last so they win over FSM updates.
      if (we) begin
         unique case (addr[3:2])
            2'd0: begin
               en_d   = wdata[0];
               mode_d = wdata[2:1];
               im_d   = wdata[3];
               flag_d = 1'b0;
            end
            2'd1: begin
               preset_d = wdata;
               flag_d   = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = 32'd0;
      unique case (addr[3:2])
         2'd0:    rdata = {28'd0, im_q, mode_q, en_q};
         2'd1:    rdata = preset_q;
         2'd2:    rdata = count_q;
         default: rdata = 32'd0;
      endcase
   end

   assign irq = im_q & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register access, one-shot, periodic,
// masked, stop/restart, simultaneous events and asynchronous reset.
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   timer_counter #(.RESET_PRESET(32'd0)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one write, sampled at the next rising edge; returns 1 time unit after it.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %0b want 0", irq); end
      addr = 32'h0; #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %0h want 0", rdata); end
      addr = 32'h4; #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_preset: got %0h want 0", rdata); end
      addr = 32'h8; #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0h want 0", rdata); end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL idle_count: got %0h want 0", rdata); end
   endtask

   task automatic test_readonly();
      wr(32'h8, 32'h1234);
      addr = 32'h8; #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL count_ro: got %0h want 0", rdata); end
      wr(32'hC, 32'hFFFF_FFFF);
      addr = 32'hC; #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL addr3_read: got %0h want 0", rdata); end
      // Read during the write cycle returns the old value.
      addr = 32'h4; wdata = 32'h55; we = 1'b1; #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL rd_pre_write: got %0h want 0", rdata); end
      @(posedge clk); #1; we = 1'b0;
      n_cmp++; if (rdata !== 32'h55) begin n_err++; $display("FAIL rd_post_write: got %0h want 55", rdata); end
   endtask

   task automatic test_oneshot();
      wr(32'h4, 32'd5);
      wr(32'h0, 32'h9);
      addr = 32'h8;
      @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (rdata !== 32'(5 - i)) begin
            n_err++; $display("FAIL os_count[%0d]: got %0d want %0d", i, rdata, 5 - i);
         end
         n_cmp++;
         if (irq !== (i == 5)) begin
            n_err++; $display("FAIL os_irq[%0d]: got %0b want %0b", i, irq, (i == 5));
         end
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL os_irq_hold: got %0b want 1", irq); end
      addr = 32'h0; #1;
      n_cmp++; if (rdata !== 32'h8) begin n_err++; $display("FAIL os_en_clr: got %0h want 8", rdata); end
      wr(32'h0, 32'h0);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL os_irq_drop: got %0b want 0", irq); end
   endtask

   task automatic test_periodic();
      wr(32'h4, 32'd3);
      wr(32'h0, 32'hB);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (irq !== (c >= 5 && (c - 5) % 6 == 0)) begin
            n_err++; $display("FAIL per_irq[%0d]: got %0b want %0b", c, irq,
                              (c >= 5 && (c - 5) % 6 == 0));
         end
      end
      addr = 32'h0; #1;
      n_cmp++; if (rdata !== 32'hB) begin n_err++; $display("FAIL per_ctrl: got %0h want b", rdata); end
      wr(32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_masked();
      wr(32'h4, 32'd10);
      wr(32'h0, 32'h1);
      addr = 32'h8;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk); #1;
         n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL msk_irq[%0d]: got %0b want 0", c, irq); end
      end
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL msk_count: got %0d want 0", rdata); end
      addr = 32'h0; #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL msk_ctrl: got %0h want 0", rdata); end
      wr(32'h0, 32'h8);
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL msk_unmask[%0d]: got %0b want 0", c, irq); end
         @(posedge clk); #1;
      end
      wr(32'h0, 32'h0);
   endtask

   task automatic test_back_to_back();
      wr(32'h4, 32'd2);
      wr(32'h0, 32'h9);
      repeat (3) @(posedge clk);
      #1;
      // Write lands on the edge that would set the flag.
      wr(32'h0, 32'h9);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL b2b_clr_wins: got %0b want 0", irq); end
      addr = 32'h8; #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL b2b_cnt0: got %0d want 0", rdata); end
      // Write lands on the INT edge; written EN wins.
      wr(32'h0, 32'h9);
      n_cmp++; if (rdata !== 32'h9) begin n_err++; $display("FAIL b2b_en_wins: got %0h want 9", rdata); end
      addr = 32'h8;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (rdata !== 32'd2) begin n_err++; $display("FAIL b2b_reload: got %0d want 2", rdata); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL b2b_irq: got %0b want 1", irq); end
      wr(32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_preset_during_run();
      wr(32'h4, 32'd20);
      wr(32'h0, 32'hB);
      repeat (4) @(posedge clk);
      #1;
      wr(32'h4, 32'd7);
      addr = 32'h8;
      for (int c = 6; c <= 34; c++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (irq !== (c == 22 || c == 32)) begin
            n_err++; $display("FAIL pr_irq[%0d]: got %0b want %0b", c, irq, (c == 22 || c == 32));
         end
         if (c == 6) begin
            n_cmp++; if (rdata !== 32'd16) begin n_err++; $display("FAIL pr_cnt6: got %0d want 16", rdata); end
         end
         if (c == 21) begin
            n_cmp++; if (rdata !== 32'd1) begin n_err++; $display("FAIL pr_cnt21: got %0d want 1", rdata); end
         end
         if (c == 25) begin
            n_cmp++; if (rdata !== 32'd7) begin n_err++; $display("FAIL pr_reload: got %0d want 7", rdata); end
         end
      end
      wr(32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_stop_and_reset();
      bit found = 1'b0;
      wr(32'h4, 32'd100);
      wr(32'h0, 32'h1);
      addr = 32'h8;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (rdata == 32'd60) found = 1'b1;
      end
      n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL stop_reach60: got %0b want 1", found); end
      wr(32'h0, 32'h0);
      addr = 32'h8;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (rdata !== 32'd59) begin n_err++; $display("FAIL stop_hold[%0d]: got %0d want 59", c, rdata); end
         n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL stop_irq[%0d]: got %0b want 0", c, irq); end
         @(posedge clk);
      end
      #1;
      wr(32'h0, 32'h1);
      addr = 32'h8;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (rdata !== 32'd100) begin n_err++; $display("FAIL stop_reload: got %0d want 100", rdata); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", rdata); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL arst_irq: got %0b want 0", irq); end
      addr = 32'h0; #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL arst_ctrl: got %0h want 0", rdata); end
      addr = 32'h4; #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL arst_preset: got %0d want 0", rdata); end
      @(negedge clk);
      reset = 1'b0;
      addr  = 32'h8;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL arst_idle: got %0d want 0", rdata); end
   endtask

   initial begin
      reset = 1'b1;
      addr  = 32'h0;
      we    = 1'b0;
      wdata = 32'h0;
      test_reset();
      test_readonly();
      test_oneshot();
      test_periodic();
      test_masked();
      test_back_to_back();
      test_preset_during_run();
      test_stop_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
